// File: rtl/pwr_seq_pkg.sv
// Shared types and constant helpers for the power sequencer.
package pwr_seq_pkg;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_DC_UP   = 3'd1,
    S_AC_UP   = 3'd2,
    S_RUN     = 3'd3,
    S_PF_WARN = 3'd4
  } pwr_state_t;

  // Bits needed to hold every value 0..max_val (never less than 1).
  function automatic int clog2(input int unsigned max_val);
    int w = 1;
    while ((64'd1 << w) <= 64'(max_val)) w++;
    return w;
  endfunction

  // Line-clock half period in clk cycles, clamped to at least one cycle.
  function automatic int half_cycles(input int clk_hz, input int ltc_hz);
    int h;
    h = clk_hz / (2 * ltc_hz);
    return (h < 1) ? 1 : h;
  endfunction

endpackage

// File: rtl/pwr_debounce.sv
// Reset-button conditioning: 2-flop synchronizer followed by a consecutive-cycle debouncer.
module pwr_debounce
  import pwr_seq_pkg::*;
#(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic rstin_n,
  output logic released
);

  localparam int CNT_W = clog2(DEB_CYC);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Button treated as pressed until it has been seen released long enough.
      sync     <= 2'b00;
      cnt      <= '0;
      released <= 1'b0;
    end else begin
      sync <= {sync[0], rstin_n};
      if (sync[1] == released) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYC - 1)) begin
        cnt      <= '0;
        released <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwr_sequencer.sv
// Power-up/down sequencer with staggered channel resets; line clock present only when
// PWR_SEQUENCER_LTC_EN is defined.
module pwr_sequencer
  import pwr_seq_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int LTC_HZ   = 50,
  parameter int DCLO_DLY = 5,
  parameter int ACLO_DLY = 3,
  parameter int PF_DLY   = 1000,
  parameter int DEB_CYC  = 16,
  parameter int NCH      = 4,
  parameter int RST_STEP = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rstin_n,
  input  logic           pwr_req,
  input  logic           ltc_en,
  output logic           dclo,
  output logic           aclo,
  output logic [NCH-1:0] ch_rst,
  output logic           ltc_irq,
  output logic           ltc_tick,
  output logic           pwr_ok
);

  localparam int DLY_MAX = (DCLO_DLY > ACLO_DLY)
                         ? ((DCLO_DLY > PF_DLY) ? DCLO_DLY : PF_DLY)
                         : ((ACLO_DLY > PF_DLY) ? ACLO_DLY : PF_DLY);
  localparam int               CNT_W   = clog2(DLY_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DLY_MAX);
  localparam int               REL_MAX = NCH * RST_STEP;
  localparam int               REL_W   = clog2(REL_MAX);
  localparam logic [REL_W-1:0] REL_TOP = REL_W'(REL_MAX);

  pwr_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [REL_W-1:0] rel, rel_next;
  logic [NCH-1:0]   ch_rst_next;
  logic             released;
  logic             req;

  pwr_debounce #(.DEB_CYC(DEB_CYC)) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .rstin_n  (rstin_n),
    .released (released)
  );

  // A press and a soft request in the same cycle collapse into one request.
  assign req = !released || pwr_req;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_OFF:     if (!req) state_next = S_DC_UP;
      S_DC_UP:   if (req) state_next = S_OFF;
                 else if (cnt == CNT_W'(DCLO_DLY - 1)) state_next = S_AC_UP;
      S_AC_UP:   if (req) state_next = S_PF_WARN;
                 else if (cnt == CNT_W'(ACLO_DLY - 1)) state_next = S_RUN;
      S_RUN:     if (req) state_next = S_PF_WARN;
      S_PF_WARN: if (cnt == CNT_W'(PF_DLY - 1)) state_next = S_OFF;
      default:   state_next = S_OFF;
    endcase

    // Dwell counter restarts on every state change and saturates instead of wrapping.
    cnt_next = cnt;
    if (state_next != state) cnt_next = '0;
    else if (cnt != CNT_MAX) cnt_next = cnt + 1'b1;

    rel_next = rel;
    if (state_next != S_RUN || state != S_RUN) rel_next = '0;
    else if (rel != REL_TOP) rel_next = rel + 1'b1;

    for (int i = 0; i < NCH; i++)
      ch_rst_next[i] = !(state_next == S_RUN && int'(rel_next) >= (i + 1) * RST_STEP);
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_OFF;
      cnt    <= '0;
      rel    <= '0;
      dclo   <= 1'b1;
      aclo   <= 1'b1;
      ch_rst <= '1;
      pwr_ok <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      rel    <= rel_next;
      dclo   <= (state_next == S_OFF) || (state_next == S_DC_UP);
      aclo   <= (state_next != S_RUN);
      ch_rst <= ch_rst_next;
      pwr_ok <= (state_next == S_RUN);
    end
  end

`ifdef PWR_SEQUENCER_LTC_EN
  localparam int               HALF     = half_cycles(CLK_HZ, LTC_HZ);
  localparam int               DIV_W    = clog2(HALF - 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(HALF - 1);

  logic [DIV_W-1:0] div;
  logic             ltc_run;

  assign ltc_run = ltc_en && (state == S_RUN || state == S_PF_WARN);

  always_ff @(posedge clk) begin
    if (reset || !ltc_run) begin
      div      <= DIV_LOAD;
      ltc_irq  <= 1'b0;
      ltc_tick <= 1'b0;
    end else if (div == '0) begin
      div      <= DIV_LOAD;
      ltc_irq  <= !ltc_irq;
      ltc_tick <= !ltc_irq;
    end else begin
      div      <= div - 1'b1;
      ltc_tick <= 1'b0;
    end
  end
`else
  localparam int UNUSED_HALF = half_cycles(CLK_HZ, LTC_HZ);
  logic unused_ltc_en;
  assign unused_ltc_en = ltc_en;
  assign ltc_irq       = 1'b0;
  assign ltc_tick      = 1'b0;
`endif

endmodule

// File: tb/tb_pwr_sequencer.sv
// Directed self-checking bench for pwr_sequencer; line-clock checks follow PWR_SEQUENCER_LTC_EN.
module tb_pwr_sequencer;

  localparam int NCH = 2;

  logic           clk = 1'b0;
  logic           reset, rstin_n, pwr_req, ltc_en;
  logic           dclo, aclo, ltc_irq, ltc_tick, pwr_ok;
  logic [NCH-1:0] ch_rst;
  int             n_checks = 0;
  int             n_pass   = 0;

  pwr_sequencer #(
    .CLK_HZ(1000), .LTC_HZ(50), .DCLO_DLY(5), .ACLO_DLY(3), .PF_DLY(10),
    .DEB_CYC(4), .NCH(NCH), .RST_STEP(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rstin_n  (rstin_n),
    .pwr_req  (pwr_req),
    .ltc_en   (ltc_en),
    .dclo     (dclo),
    .aclo     (aclo),
    .ch_rst   (ch_rst),
    .ltc_irq  (ltc_irq),
    .ltc_tick (ltc_tick),
    .pwr_ok   (pwr_ok)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns past the edge before sampling/driving.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_dclo, input logic e_aclo,
                            input logic [NCH-1:0] e_ch, input logic e_ok);
    check({tag, ".dclo"}, dclo, e_dclo);
    check({tag, ".aclo"}, aclo, e_aclo);
    check_vec({tag, ".ch_rst"}, ch_rst, e_ch);
    check({tag, ".pwr_ok"}, pwr_ok, e_ok);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; rstin_n = 1'b0; pwr_req = 1'b0; ltc_en = 1'b0;
    step(3);
    check_outs("reset", 1'b1, 1'b1, 2'b11, 1'b0);
    check("reset.ltc_irq", ltc_irq, 1'b0);
    check("reset.ltc_tick", ltc_tick, 1'b0);

    // Power-up: sync 2 + debounce 4 -> released at edge 6, DC_UP 7, AC_UP 12, RUN 15.
    reset = 1'b0; rstin_n = 1'b1;
    step(11); check("up.dclo_held", dclo, 1'b1);
    step(1);  check("up.dclo_rel", dclo, 1'b0); check("up.aclo_held", aclo, 1'b1);
    step(2);  check("up.aclo_held2", aclo, 1'b1);
    step(1);  check_outs("up.run", 1'b0, 1'b0, 2'b11, 1'b1);
    step(1);  check_vec("up.ch_hold", ch_rst, 2'b11);
    step(1);  check_vec("up.ch0_rel", ch_rst, 2'b10);
    step(1);  check_vec("up.ch1_hold", ch_rst, 2'b10);
    step(1);  check_vec("up.ch1_rel", ch_rst, 2'b00);

    // Line clock: HALF = 1000/(2*50) = 10, first toggle 10 edges after enable.
    ltc_en = 1'b1;
`ifdef PWR_SEQUENCER_LTC_EN
    step(9);  check("ltc.pre", ltc_irq, 1'b0);
    step(1);  check("ltc.rise1", ltc_irq, 1'b1); check("ltc.tick1", ltc_tick, 1'b1);
    step(1);  check("ltc.tick_width", ltc_tick, 1'b0); check("ltc.high", ltc_irq, 1'b1);
    step(9);  check("ltc.fall", ltc_irq, 1'b0); check("ltc.no_tick_fall", ltc_tick, 1'b0);
    step(10); check("ltc.rise2", ltc_irq, 1'b1); check("ltc.tick2", ltc_tick, 1'b1);
`else
    step(30); check("ltc.tied_irq", ltc_irq, 1'b0); check("ltc.tied_tick", ltc_tick, 1'b0);
`endif
    ltc_en = 1'b0;
    step(1);  check("ltc.off", ltc_irq, 1'b0);

    // Three-cycle bounce must be rejected.
    rstin_n = 1'b0; step(3); rstin_n = 1'b1;
    step(10); check_outs("bounce", 1'b0, 1'b0, 2'b00, 1'b1);

    // Four-cycle press: released drops at b+6, PF_WARN b+7, OFF b+17, back in RUN b+26.
    rstin_n = 1'b0; step(4); rstin_n = 1'b1;
    step(2);  check_outs("press.still_run", 1'b0, 1'b0, 2'b00, 1'b1);
    step(1);  check_outs("press.pf", 1'b0, 1'b1, 2'b11, 1'b0);
    step(9);  check("press.pf_dclo", dclo, 1'b0);
    step(1);  check_outs("press.off", 1'b1, 1'b1, 2'b11, 1'b0);
    step(13); check_outs("press.rerun", 1'b0, 1'b0, 2'b00, 1'b1);

    // Held pwr_req: PF_WARN at c+1, OFF c+11, stays OFF until release at c+15.
    pwr_req = 1'b1;
    step(1);  check_outs("req.pf", 1'b0, 1'b1, 2'b11, 1'b0);
    step(9);  check("req.pf_dclo", dclo, 1'b0);
    step(1);  check("req.off", dclo, 1'b1);
    step(4);  check("req.held_off", dclo, 1'b1);
    pwr_req = 1'b0;
    step(5);  check("req.dc_up", dclo, 1'b1);
    step(1);  check("req.ac_up_dclo", dclo, 1'b0); check("req.ac_up_aclo", aclo, 1'b1);

    // Request during AC_UP -> PF_WARN, never reaching RUN.
    pwr_req = 1'b1; step(1); pwr_req = 1'b0;
    check_outs("acup.pf", 1'b0, 1'b1, 2'b11, 1'b0);
    step(2);  check("acup.no_run_aclo", aclo, 1'b1); check("acup.no_run_ok", pwr_ok, 1'b0);
    step(7);  check("acup.pf_dclo", dclo, 1'b0);
    step(1);  check("acup.off", dclo, 1'b1);

    // Request during DC_UP -> OFF; dclo/aclo stay asserted through the restart.
    step(1);
    pwr_req = 1'b1; step(1); pwr_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("dcup.dclo_held", dclo, 1'b1);
      check("dcup.aclo_held", aclo, 1'b1);
      step(1);
    end
    check("dcup.dclo_rel", dclo, 1'b0); check("dcup.aclo", aclo, 1'b1);

    // Reset asserted in the middle of PF_WARN.
    step(7);  check_outs("rst.run", 1'b0, 1'b0, 2'b00, 1'b1);
    pwr_req = 1'b1; ltc_en = 1'b1;
    step(1);  pwr_req = 1'b0;
    step(4);  check_outs("rst.in_pf", 1'b0, 1'b1, 2'b11, 1'b0);
    reset = 1'b1;
    step(1);  check_outs("rst.mid_pf", 1'b1, 1'b1, 2'b11, 1'b0);
    check("rst.ltc_irq", ltc_irq, 1'b0); check("rst.ltc_tick", ltc_tick, 1'b0);
    ltc_en = 1'b0;
    step(1);  reset = 1'b0;

    // Debouncer restarts from "pressed": same 12-edge path to dclo release.
    step(11); check("rst.dclo_held", dclo, 1'b1);
    step(1);  check("rst.dclo_rel", dclo, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwr_sequencer.md
PWR_SEQUENCER -- requirements
Module: pwr_sequencer

Interface
REQ-001 Parameter CLK_HZ, 50000000, clk frequency in Hz.
REQ-002 Parameter LTC_HZ, 50, line-time clock frequency in Hz.
REQ-003 Parameter DCLO_DLY, 5, cycles spent in DC_UP before dclo release; range 1..65535.
REQ-004 Parameter ACLO_DLY, 3, cycles spent in AC_UP before aclo release; range 1..65535.
REQ-005 Parameter PF_DLY, 1000, power-fail warning cycles (aclo=1, dclo=0) before dclo reassert; range 1..65535.
REQ-006 Parameter DEB_CYC, 16, consecutive stable cycles required by the button debouncer; range 1..65535.
REQ-007 Parameter NCH, 4, staggered peripheral reset channels; range 1..16.
REQ-008 Parameter RST_STEP, 8, cycles between successive channel releases; range 1..255.
REQ-009 clk  in  1  clock, rising edge.
REQ-010 reset  in  1  synchronous, active-high.
REQ-011 rstin_n  in  1  asynchronous reset button, 0 = pressed.
REQ-012 pwr_req  in  1  synchronous soft power-down request, level.
REQ-013 ltc_en  in  1  line-clock enable.
REQ-014 dclo  out  1  DC-low, 1 = asserted.
REQ-015 aclo  out  1  AC-low, 1 = asserted.
REQ-016 ch_rst  out  NCH  per-channel reset, 1 = asserted.
REQ-017 ltc_irq  out  1  line-clock square wave.
REQ-018 ltc_tick  out  1  one-cycle strobe on every ltc_irq rising edge.
REQ-019 pwr_ok  out  1  high only in RUN.

Function
REQ-020 rstin_n passes a 2-flop synchronizer, then the debouncer; debounced output changes only after the synchronized input differs from it for DEB_CYC consecutive cycles; any bounce restarts the count.
REQ-021 States: OFF, DC_UP, AC_UP, RUN, PF_WARN; all outputs registered.
REQ-022 OFF: dclo=1, aclo=1; -> DC_UP when debounced button released and pwr_req=0.
REQ-023 DC_UP: dclo=1, aclo=1; exactly DCLO_DLY cycles, then -> AC_UP; press or pwr_req -> OFF.
REQ-024 AC_UP: dclo=0, aclo=1; exactly ACLO_DLY cycles, then -> RUN; press or pwr_req -> PF_WARN.
REQ-025 RUN: dclo=0, aclo=0; press or pwr_req -> PF_WARN.
REQ-026 PF_WARN: dclo=0, aclo=1; exactly PF_DLY cycles, then -> OFF; further requests ignored.
REQ-027 ch_rst[i] deasserts (i+1)*RST_STEP cycles after RUN entry; leaving RUN before release keeps it asserted.
REQ-028 All ch_rst bits reassert on the first cycle of PF_WARN or OFF.
REQ-029 Line clock runs only in RUN or PF_WARN with ltc_en=1; ltc_irq toggles every HALF = CLK_HZ/(2*LTC_HZ) cycles (integer divide, minimum 1).
REQ-030 Otherwise the divider reloads HALF and ltc_irq=0; the first toggle comes HALF cycles after the enable condition becomes true.
REQ-031 Press and pwr_req in the same cycle are one request.
REQ-032 All counter widths derive from the parameter maximum via a clog2 function; no counter wraps.

Reset
REQ-033 reset=1 forces OFF from any state: dclo=1, aclo=1, ch_rst all 1, ltc_irq=0, ltc_tick=0, pwr_ok=0; all counters cleared.
REQ-034 reset sets synchronizer and debouncer state to "pressed", so power-up needs DEB_CYC stable released cycles after reset.

Configuration
REQ-035 PWR_SEQUENCER_LTC_EN defined: line clock per REQ-029/030.
REQ-036 PWR_SEQUENCER_LTC_EN undefined: no divider logic; ltc_irq and ltc_tick tied 0; ltc_en unused.

Structure
REQ-037 Package pwr_seq_pkg holds the state encoding, the clog2 function and the HALF computation.
REQ-038 Sub-module pwr_debounce (synchronizer plus debouncer, parameter DEB_CYC).

Verification (DCLO_DLY=5, ACLO_DLY=3, PF_DLY=10, DEB_CYC=4, NCH=2, RST_STEP=2, CLK_HZ=1000, LTC_HZ=50)
REQ-039 Release reset, rstin_n=1 -> DC_UP after 2+4 cycles; dclo falls 5 cycles later; aclo falls 3 cycles after that; ch_rst[0] falls 2 and ch_rst[1] 4 cycles after RUN entry.
REQ-040 In RUN, ltc_en=1 -> ltc_irq period 20 cycles, ltc_tick one cycle wide per rising edge; ltc_en=0 -> ltc_irq=0.
REQ-041 In RUN, pwr_req pulse -> aclo=1 and ch_rst=11 next state; dclo=1 after 10 cycles; then OFF, restart once pwr_req=0.
REQ-042 Bounce rstin_n low for 3 cycles in RUN -> no state change; low for 4+ cycles -> PF_WARN.
REQ-043 pwr_req during DC_UP -> OFF with aclo and dclo never released; during AC_UP -> PF_WARN.
REQ-044 reset asserted mid-PF_WARN -> all outputs at reset values the next cycle.
